// File: rtl/first_nios2_system_cpu_oci_dct_packer_pkg.sv
// first_nios2_system_cpu_oci_dct_packer_pkg: shared OCI trace packing widths and sequencing states
package first_nios2_system_cpu_oci_dct_packer_pkg;
  localparam int SYM_W = 3;
  localparam int DCT_W = 30;
  localparam int DCT_SLOTS = 10;
  typedef enum logic [1:0] {RUN, DRAIN, ENDING, ENDED} state_t;
endpackage

// File: rtl/first_nios2_system_cpu_oci_dct_packer_if.sv
// first_nios2_system_cpu_oci_dct_packer_if: trace symbol input, packed word output and end-of-test signals
interface first_nios2_system_cpu_oci_dct_packer_if;
  import first_nios2_system_cpu_oci_dct_packer_pkg::*;
  logic             sym_valid;
  logic [SYM_W-1:0] sym;
  logic             sym_ready;
  logic             flush;
  logic             end_req;
  logic [DCT_W-1:0] dct_buffer;
  logic [3:0]       dct_count;
  logic             dct_valid;
  logic             dct_ready;
  logic             test_ending;
  logic             test_has_ended;
  modport master (
    input  sym_valid, sym, flush, end_req, dct_ready,
    output sym_ready, dct_buffer, dct_count, dct_valid, test_ending, test_has_ended
  );
  modport slave (
    output sym_valid, sym, flush, end_req, dct_ready,
    input  sym_ready, dct_buffer, dct_count, dct_valid, test_ending, test_has_ended
  );
endinterface

// File: rtl/first_nios2_system_cpu_oci_dct_out_reg.sv
// first_nios2_system_cpu_oci_dct_out_reg: one-entry valid/ready holding register for a packed trace word
module first_nios2_system_cpu_oci_dct_out_reg
  import first_nios2_system_cpu_oci_dct_packer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [DCT_W-1:0] i_buf,
  input  logic [3:0]       i_cnt,
  input  logic             i_ready,
  output logic [DCT_W-1:0] o_buf,
  output logic [3:0]       o_cnt,
  output logic             o_valid,
  output logic             o_free
);
  logic [DCT_W-1:0] r_buf;
  logic [3:0]       r_cnt;
  logic             r_valid;
  assign o_buf = r_buf;
  assign o_cnt = r_cnt;
  assign o_valid = r_valid;
  assign o_free = !r_valid || i_ready;
  // load a new word when free, otherwise drop valid once the consumer takes it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf <= '0;
      r_cnt <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_buf <= i_buf;
      r_cnt <= i_cnt;
      r_valid <= 1'b1;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/first_nios2_system_cpu_oci_dct_packer.sv
// first_nios2_system_cpu_oci_dct_packer: packs 3-bit trace symbols into 30-bit words and sequences end-of-test
module first_nios2_system_cpu_oci_dct_packer
  import first_nios2_system_cpu_oci_dct_packer_pkg::*;
#(
  parameter int FLUSH_TIMEOUT = 64
) (
  input logic clk,
  input logic reset,
  first_nios2_system_cpu_oci_dct_packer_if.master bus
);
  state_t           r_state, w_state_n;
  logic [DCT_W-1:0] r_acc_buf, w_buf_n, w_sym_sh;
  logic [3:0]       r_acc_cnt, w_cnt_n, w_out_cnt;
  logic [7:0]       r_idle;
  logic             r_pend;
  logic             w_acc, w_full, w_expire, w_req, w_xfer, w_free;
  assign w_full = r_acc_cnt == 4'(DCT_SLOTS);
  assign bus.sym_ready = r_state == RUN && !(w_full && !w_free);
  assign w_acc = bus.sym_valid && bus.sym_ready;
  assign w_sym_sh = DCT_W'(bus.sym) << (SYM_W * int'(r_acc_cnt));
  assign w_buf_n = r_acc_buf | (w_acc ? w_sym_sh : '0);
  assign w_cnt_n = r_acc_cnt + 4'(w_acc);
  assign w_out_cnt = w_full ? 4'(DCT_SLOTS) : w_cnt_n;
  assign w_expire = r_acc_cnt != 0 && r_idle == 8'(FLUSH_TIMEOUT - 1);
  assign w_req = w_full || w_cnt_n == 4'(DCT_SLOTS) || r_pend || w_expire
              || ((bus.flush || r_state == DRAIN) && w_cnt_n != 0);
  assign w_xfer = w_req && w_free;
  assign bus.test_ending = r_state == ENDING || r_state == ENDED;
  assign bus.test_has_ended = r_state == ENDED;
  first_nios2_system_cpu_oci_dct_out_reg u_out (
    .clk(clk),
    .reset(reset),
    .i_load(w_xfer),
    .i_buf(w_buf_n),
    .i_cnt(w_out_cnt),
    .i_ready(bus.dct_ready),
    .o_buf(bus.dct_buffer),
    .o_cnt(bus.dct_count),
    .o_valid(bus.dct_valid),
    .o_free(w_free)
  );
  // accumulator, idle counter and pending-transfer flag; a symbol arriving while a full word leaves starts the next word
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc_buf <= '0;
      r_acc_cnt <= '0;
      r_idle <= '0;
      r_pend <= 1'b0;
    end else begin
      r_acc_buf <= w_xfer ? ((w_full && w_acc) ? DCT_W'(bus.sym) : '0) : w_buf_n;
      r_acc_cnt <= w_xfer ? 4'(w_full && w_acc) : w_cnt_n;
      r_idle <= (w_acc || r_acc_cnt == 0 || w_xfer) ? '0 : w_expire ? r_idle : r_idle + 8'd1;
      r_pend <= w_req && !w_xfer;
    end
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= RUN;
    else r_state <= w_state_n;
  end
  // leave DRAIN as soon as the last word is being consumed so test_ending follows it by one cycle
  always_comb begin
    w_state_n = r_state;
    w_state_n = (r_state == RUN && bus.end_req) ? DRAIN
              : (r_state == DRAIN && r_acc_cnt == 0 && w_free) ? ENDING
              : (r_state == ENDING) ? ENDED
              : r_state;
  end
endmodule

// File: tb/tb_first_nios2_system_cpu_oci_dct_packer.sv
// tb_first_nios2_system_cpu_oci_dct_packer: directed and randomized checks against a symbol-queue reference model
module tb_first_nios2_system_cpu_oci_dct_packer;
  import first_nios2_system_cpu_oci_dct_packer_pkg::*;
  localparam int T = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  first_nios2_system_cpu_oci_dct_packer_if bus();
  first_nios2_system_cpu_oci_dct_packer #(.FLUSH_TIMEOUT(T)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  int checks = 0;
  int errors = 0;
  int n_acc = 0;
  logic last_acc = 1'b0;
  logic [2:0] q[$];
  int cnts[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    logic [29:0] e;
    #1;
    last_acc = bus.sym_valid && bus.sym_ready;
    if (last_acc) begin
      q.push_back(bus.sym);
      n_acc++;
    end
    if (bus.dct_valid && bus.dct_ready) begin
      chk("sb_count_range", 32'(bus.dct_count >= 1 && bus.dct_count <= 10 && int'(bus.dct_count) <= q.size()), 1);
      e = '0;
      for (int k = 0; k < int'(bus.dct_count) && q.size() > 0; k++) e |= 30'(q.pop_front()) << (3 * k);
      chk("sb_word", 32'(bus.dct_buffer), 32'(e));
      cnts.push_back(int'(bus.dct_count));
    end
    @(posedge clk);
    #1;
  endtask
  task automatic feed(input logic [2:0] v);
    bus.sym = v;
    bus.sym_valid = 1'b1;
    for (int g = 0; g < 40; g++) begin
      tick();
      if (last_acc) break;
    end
    bus.sym_valid = 1'b0;
    chk("feed_accept", 32'(last_acc), 1);
  endtask
  task automatic wait_valid(input int max);
    for (int g = 0; g < max; g++) begin
      if (bus.dct_valid) break;
      tick();
    end
    chk("wait_valid", 32'(bus.dct_valid), 1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [2:0] seq[10];
    int b;
    seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    bus.sym_valid = 1'b0;
    bus.sym = '0;
    bus.flush = 1'b0;
    bus.end_req = 1'b0;
    bus.dct_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_valid", 32'(bus.dct_valid), 0);
    chk("rst_buffer", 32'(bus.dct_buffer), 0);
    chk("rst_count", 32'(bus.dct_count), 0);
    chk("rst_ending", 32'(bus.test_ending), 0);
    chk("rst_ended", 32'(bus.test_has_ended), 0);
    chk("rst_sym_ready", 32'(bus.sym_ready), 1);
    bus.dct_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) chk("full_not_early", 32'(bus.dct_valid), 0);
      feed(seq[i]);
    end
    chk("full_valid", 32'(bus.dct_valid), 1);
    chk("full_count", 32'(bus.dct_count), 10);
    chk("full_buffer", 32'(bus.dct_buffer), 32'h08FA_C688);
    feed(3'd5);
    feed(3'd2);
    feed(3'd7);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_valid", 32'(bus.dct_valid), 1);
    chk("flush_buffer", 32'(bus.dct_buffer), 32'h1D5);
    chk("flush_count", 32'(bus.dct_count), 3);
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    tick();
    tick();
    chk("flush_empty_no_word", 32'(bus.dct_valid), 0);
    feed(3'd6);
    for (int i = 0; i < T; i++) begin
      chk("timeout_wait", 32'(bus.dct_valid), 0);
      tick();
    end
    chk("timeout_valid", 32'(bus.dct_valid), 1);
    chk("timeout_count", 32'(bus.dct_count), 1);
    chk("timeout_buffer", 32'(bus.dct_buffer), 6);
    tick();
    b = cnts.size();
    bus.dct_ready = 1'b0;
    for (int i = 0; i < 20; i++) feed(3'($urandom_range(0, 7)));
    bus.sym = 3'($urandom_range(0, 7));
    bus.sym_valid = 1'b1;
    chk("bp_sym_ready_low", 32'(bus.sym_ready), 0);
    chk("bp_out_count", 32'(bus.dct_count), 10);
    tick();
    tick();
    tick();
    chk("bp_still_blocked", 32'(q.size()), 20);
    bus.dct_ready = 1'b1;
    for (int g = 0; g < 40 && q.size() + 10 * (cnts.size() - b) < 25; g++) begin
      tick();
      bus.sym = 3'($urandom_range(0, 7));
    end
    bus.sym_valid = 1'b0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("bp_words", 32'(cnts.size() - b), 3);
    chk("bp_cnt0", 32'(cnts.size() > b ? cnts[b] : 0), 10);
    chk("bp_cnt1", 32'(cnts.size() > b + 1 ? cnts[b + 1] : 0), 10);
    chk("bp_cnt2", 32'(cnts.size() > b + 2 ? cnts[b + 2] : 0), 5);
    for (int i = 0; i < 400; i++) begin
      bus.sym_valid = 1'($urandom_range(0, 1));
      bus.sym = 3'($urandom_range(0, 7));
      bus.flush = $urandom_range(0, 15) == 0;
      bus.dct_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    bus.sym_valid = 1'b0;
    bus.flush = 1'b0;
    bus.dct_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("rand_drained", 32'(q.size()), 0);
    chk("rand_idle_valid", 32'(bus.dct_valid), 0);
    for (int i = 0; i < 7; i++) feed(3'($urandom_range(0, 7)));
    bus.dct_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q.delete();
    chk("mid_rst_valid", 32'(bus.dct_valid), 0);
    chk("mid_rst_buffer", 32'(bus.dct_buffer), 0);
    chk("mid_rst_count", 32'(bus.dct_count), 0);
    chk("mid_rst_ending", 32'(bus.test_ending | bus.test_has_ended), 0);
    chk("mid_rst_sym_ready", 32'(bus.sym_ready), 1);
    for (int i = 0; i < T + 2; i++) tick();
    chk("mid_rst_no_word", 32'(bus.dct_valid), 0);
    bus.dct_ready = 1'b1;
    for (int i = 0; i < 10; i++) feed(3'($urandom_range(0, 7)));
    chk("post_rst_valid", 32'(bus.dct_valid), 1);
    chk("post_rst_count", 32'(bus.dct_count), 10);
    tick();
    bus.dct_ready = 1'b0;
    for (int i = 0; i < 4; i++) feed(3'($urandom_range(0, 7)));
    bus.end_req = 1'b1;
    tick();
    bus.end_req = 1'b0;
    chk("end_sym_ready", 32'(bus.sym_ready), 0);
    wait_valid(5);
    chk("end_count", 32'(bus.dct_count), 4);
    chk("end_not_yet", 32'(bus.test_ending), 0);
    bus.dct_ready = 1'b1;
    tick();
    chk("end_ending", 32'(bus.test_ending), 1);
    chk("end_has_not", 32'(bus.test_has_ended), 0);
    tick();
    chk("end_ending_hold", 32'(bus.test_ending), 1);
    chk("end_has_ended", 32'(bus.test_has_ended), 1);
    bus.end_req = 1'b1;
    tick();
    bus.end_req = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("end_sticky", 32'({bus.test_ending, bus.test_has_ended}), 3);
    chk("end_drained", 32'(q.size()), 0);
    chk("end_no_accept", 32'(bus.sym_ready), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
